// File: rtl/data_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_pkg
// Purpose  : Shared types and constants for the MEM-stage data bus responder.
// Revision : 1.0 - initial release
// ============================================================================
package data_bus_pkg;

  // Responder transaction FSM
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Byte offsets of the I/O registers relative to IO_BASE
  localparam logic [31:0] GPIO_OUT_OFS = 32'd0;
  localparam logic [31:0] GPIO_IN_OFS  = 32'd4;
  localparam logic [31:0] CNT_OFS      = 32'd8;

  // Where a latched request is routed; DEC_ERR covers every illegal access
  typedef enum logic [2:0] {
    DEC_RAM      = 3'd0,
    DEC_GPIO_OUT = 3'd1,
    DEC_GPIO_IN  = 3'd2,
    DEC_CNT      = 3'd3,
    DEC_ERR      = 3'd4
  } decode_t;

  // True when a byte address names one specific I/O register
  function automatic logic io_match(input logic [31:0] addr,
                                    input logic [31:0] io_base,
                                    input logic [31:0] ofs);
    return addr == (io_base + ofs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_bus_ram.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_ram
// Purpose  : Single-port synchronous word RAM with registered read data.
// Revision : 1.0 - initial release
// ============================================================================
module data_bus_ram #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH];

  // Write on we_i; read data is the pre-write contents, registered
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end

endmodule
`default_nettype wire

// File: rtl/data_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_responder
// Purpose  : Target side of the MEM-stage load/store bus: RAM, GPIO and a
//            free-running cycle counter behind a wait-state FSM.
// Revision : 1.0 - initial release
// ============================================================================
module data_bus_responder
  import data_bus_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 256,
  parameter logic [31:0] RAM_BASE     = 32'h1001_0000,
  parameter logic [31:0] IO_BASE      = 32'h1001_FFF0,
  parameter int          WAIT_STATES  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [31:0] address_i,
  input  logic [31:0] write_data_i,
  input  logic [31:0] gpio_i,
  output logic [31:0] data_o,
  output logic        ready_o,
  output logic        error_o,
  output logic        busy_o,
  output logic [31:0] gpio_o
);

  localparam int          ADDR_W    = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(4 * MEMORY_DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  state_t              state_q;
  logic [3:0]          wcnt_q;
  decode_t             dec_q;
  decode_t             dec_d;
  logic                is_wr_q;
  logic [ADDR_W-1:0]   ram_idx_q;
  logic [31:0]         wdata_q;
  logic [31:0]         data_q;
  logic                ready_q;
  logic                error_q;
  logic                busy_q;
  logic [31:0]         gpio_q;
  logic [31:0]         cnt_q;
  logic [31:0]         gpio_sync1_q;
  logic [31:0]         gpio_sync2_q;

  logic [31:0]         ram_ofs;
  logic [ADDR_W-1:0]   ram_idx_in;
  logic [ADDR_W-1:0]   ram_addr;
  logic                ram_we;
  logic [31:0]         ram_rdata;
  logic                cnt_we;

  assign ram_ofs    = address_i - RAM_BASE;
  assign ram_idx_in = ram_ofs[ADDR_W+1:2];

  // Classify the incoming request; only consumed on the acceptance edge
  always_comb begin
    dec_d = DEC_ERR;
    if (mem_read_i && mem_write_i) begin
      dec_d = DEC_ERR;
    end else if (address_i[1:0] != 2'b00) begin
      dec_d = DEC_ERR;
    end else if ((address_i >= RAM_BASE) && (ram_ofs < RAM_BYTES)) begin
      dec_d = DEC_RAM;
    end else if (io_match(address_i, IO_BASE, GPIO_OUT_OFS)) begin
      dec_d = DEC_GPIO_OUT;
    end else if (io_match(address_i, IO_BASE, GPIO_IN_OFS)) begin
      dec_d = mem_write_i ? DEC_ERR : DEC_GPIO_IN;
    end else if (io_match(address_i, IO_BASE, CNT_OFS)) begin
      dec_d = DEC_CNT;
    end
  end

  // The RAM is addressed from the live bus while idle so that its registered
  // read is already valid during the RESP cycle even with zero wait states.
  assign ram_addr = (state_q == ST_IDLE) ? ram_idx_in : ram_idx_q;
  assign ram_we   = (state_q == ST_RESP) && is_wr_q && (dec_q == DEC_RAM);
  assign cnt_we   = (state_q == ST_RESP) && is_wr_q && (dec_q == DEC_CNT);

  data_bus_ram #(
    .DEPTH  (MEMORY_DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  // Two-flop synchroniser for the external input port
  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_sync1_q <= 32'd0;
      gpio_sync2_q <= 32'd0;
    end else begin
      gpio_sync1_q <= gpio_i;
      gpio_sync2_q <= gpio_sync1_q;
    end
  end

  // Free-running cycle counter; a bus store replaces this cycle's increment
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 32'd0;
    end else if (cnt_we) begin
      cnt_q <= wdata_q;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  // Transaction FSM with registered handshake, read data and GPIO output
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wcnt_q    <= 4'd0;
      dec_q     <= DEC_ERR;
      is_wr_q   <= 1'b0;
      ram_idx_q <= '0;
      wdata_q   <= 32'd0;
      data_q    <= 32'd0;
      ready_q   <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
      gpio_q    <= 32'd0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (mem_read_i || mem_write_i) begin
            dec_q     <= dec_d;
            is_wr_q   <= mem_write_i;
            ram_idx_q <= ram_idx_in;
            wdata_q   <= write_data_i;
            wcnt_q    <= WAIT_INIT;
            if (WAIT_INIT != 4'd0) begin
              state_q <= ST_WAIT;
              busy_q  <= 1'b1;
            end else begin
              state_q <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          wcnt_q <= wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) begin
            state_q <= ST_RESP;
            busy_q  <= 1'b0;
          end
        end
        ST_RESP: begin
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          error_q <= (dec_q == DEC_ERR);
          state_q <= ST_IDLE;
          case (dec_q)
            DEC_RAM: begin
              if (!is_wr_q) data_q <= ram_rdata;
            end
            DEC_GPIO_OUT: begin
              if (is_wr_q) gpio_q <= wdata_q;
              else         data_q <= gpio_q;
            end
            DEC_GPIO_IN: data_q <= gpio_sync2_q;
            DEC_CNT: begin
              if (!is_wr_q) data_q <= cnt_q;
            end
            default: data_q <= 32'd0;
          endcase
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_o  = data_q;
  assign ready_o = ready_q;
  assign error_o = error_q;
  assign busy_o  = busy_q;
  assign gpio_o  = gpio_q;

endmodule
`default_nettype wire

// File: tb/tb_data_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_bus_responder
// Purpose  : Self-checking bench for data_bus_responder; three instances with
//            0, 1 and 3 wait states against a behavioural bus model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_bus_responder;

  localparam logic [31:0] RAM_BASE = 32'h1001_0000;
  localparam logic [31:0] IO_BASE  = 32'h1001_FFF0;
  localparam int          DEPTH    = 256;
  localparam int          WS [3]   = '{1, 0, 3};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst  [3];
  logic        rd   [3];
  logic        wr   [3];
  logic [31:0] addr [3];
  logic [31:0] wd   [3];
  logic [31:0] gin  [3];
  logic [31:0] dout [3];
  logic        rdy  [3];
  logic        err  [3];
  logic        busy [3];
  logic [31:0] gout [3];

  data_bus_responder #(.MEMORY_DEPTH(DEPTH), .RAM_BASE(RAM_BASE), .IO_BASE(IO_BASE), .WAIT_STATES(1)) u_dut0 (
    .clk(clk), .reset(rst[0]), .mem_read_i(rd[0]), .mem_write_i(wr[0]), .address_i(addr[0]),
    .write_data_i(wd[0]), .gpio_i(gin[0]), .data_o(dout[0]), .ready_o(rdy[0]), .error_o(err[0]),
    .busy_o(busy[0]), .gpio_o(gout[0]));

  data_bus_responder #(.MEMORY_DEPTH(DEPTH), .RAM_BASE(RAM_BASE), .IO_BASE(IO_BASE), .WAIT_STATES(0)) u_dut1 (
    .clk(clk), .reset(rst[1]), .mem_read_i(rd[1]), .mem_write_i(wr[1]), .address_i(addr[1]),
    .write_data_i(wd[1]), .gpio_i(gin[1]), .data_o(dout[1]), .ready_o(rdy[1]), .error_o(err[1]),
    .busy_o(busy[1]), .gpio_o(gout[1]));

  data_bus_responder #(.MEMORY_DEPTH(DEPTH), .RAM_BASE(RAM_BASE), .IO_BASE(IO_BASE), .WAIT_STATES(3)) u_dut2 (
    .clk(clk), .reset(rst[2]), .mem_read_i(rd[2]), .mem_write_i(wr[2]), .address_i(addr[2]),
    .write_data_i(wd[2]), .gpio_i(gin[2]), .data_o(dout[2]), .ready_o(rdy[2]), .error_o(err[2]),
    .busy_o(busy[2]), .gpio_o(gout[2]));

  // Behavioural model state
  logic [31:0] mram      [3][DEPTH];
  bit          mval      [3][DEPTH];
  logic [31:0] mgpio     [3];
  logic [31:0] cbase_val [3];
  int          cbase_edge[3];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  // Edge count; a sampled reset pins the counter model to 0 at that edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int d = 0; d < 3; d++) begin
      if (rst[d]) begin
        cbase_edge[d] = cyc;
        cbase_val[d]  = 32'd0;
        mgpio[d]      = 32'd0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Expected outcome of one access completing on edge resp_edge
  task automatic predict(input int d, input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] wdat, input int resp_edge,
                         output logic [31:0] exp_d, output logic exp_e, output bit dcheck);
    int idx;
    exp_e  = 1'b0;
    exp_d  = 32'd0;
    dcheck = 1'b0;
    if ((r && w) || (a % 4 != 0)) begin
      exp_e = 1'b1;
    end else if (a >= RAM_BASE && a < RAM_BASE + 4 * DEPTH) begin
      idx = int'((a - RAM_BASE) / 4);
      if (w) begin
        mram[d][idx] = wdat;
        mval[d][idx] = 1'b1;
      end else begin
        exp_d  = mram[d][idx];
        dcheck = mval[d][idx];
      end
    end else if (a == IO_BASE) begin
      if (w) mgpio[d] = wdat;
      else begin exp_d = mgpio[d]; dcheck = 1'b1; end
    end else if (a == IO_BASE + 4) begin
      if (w) exp_e = 1'b1;
      else begin exp_d = gin[d]; dcheck = 1'b1; end
    end else if (a == IO_BASE + 8) begin
      if (w) begin
        cbase_val[d]  = wdat;
        cbase_edge[d] = resp_edge;
      end else begin
        exp_d  = cbase_val[d] + 32'(resp_edge - 1 - cbase_edge[d]);
        dcheck = 1'b1;
      end
    end else begin
      exp_e = 1'b1;
    end
    if (exp_e) dcheck = 1'b1;
  endtask

  // Full request/response handshake on instance d, checked against the model
  task automatic txn(input int d, input bit r, input bit w, input logic [31:0] a,
                     input logic [31:0] wdat, input string tag);
    int          e0, e, nb;
    bit          got, dchk;
    logic [31:0] exp_d;
    logic        exp_e;
    @(negedge clk);
    rd[d] = r; wr[d] = w; addr[d] = a; wd[d] = wdat;
    @(posedge clk);
    #1 e0 = cyc;
    got = 1'b0; nb = 0; e = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (busy[d]) nb++;
      if (rdy[d]) begin
        got = 1'b1;
        e   = cyc;
      end
    end
    rd[d] = 1'b0; wr[d] = 1'b0;
    if (!got) begin
      chk({tag, " ready timeout"}, 32'd0, 32'd1);
      return;
    end
    predict(d, r, w, a, wdat, e, exp_d, exp_e, dchk);
    chk({tag, " latency"}, 32'(e - e0), 32'(WS[d] + 1));
    chk({tag, " busy cycles"}, 32'(nb), 32'(WS[d]));
    chk({tag, " error"}, 32'(err[d]), 32'(exp_e));
    if (dchk) chk({tag, " data"}, dout[d], exp_d);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          nrdy;
    logic [31:0] a, v;
    int          op, cls;
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; rd[d] = 1'b0; wr[d] = 1'b0;
      addr[d] = 32'd0; wd[d] = 32'd0; gin[d] = 32'd0;
      for (int i = 0; i < DEPTH; i++) mval[d][i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset data_o",  dout[d], 32'd0);
      chk("reset ready_o", 32'(rdy[d]), 32'd0);
      chk("reset error_o", 32'(err[d]), 32'd0);
      chk("reset busy_o",  32'(busy[d]), 32'd0);
      chk("reset gpio_o",  gout[d], 32'd0);
    end
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;

    // Store then load with one wait state
    txn(0, 0, 1, 32'h1001_0004, 32'hDEAD_BEEF, "st ws1");
    txn(0, 1, 0, 32'h1001_0004, 32'h0, "ld ws1");
    chk("ld ws1 literal", dout[0], 32'hDEAD_BEEF);

    // Error cases
    txn(0, 1, 0, 32'h1001_0002, 32'h0, "misaligned");
    txn(0, 1, 1, 32'h1001_0004, 32'h0BAD_0BAD, "rd+wr");
    txn(0, 1, 0, 32'h1001_0004, 32'h0, "after rd+wr");
    txn(0, 0, 1, IO_BASE + 4, 32'h5555_5555, "wr gpio_in");

    // GPIO
    txn(0, 0, 1, IO_BASE, 32'h0000_00A5, "wr gpio_out");
    chk("gpio_o", gout[0], 32'h0000_00A5);
    txn(0, 1, 0, IO_BASE, 32'h0, "rd gpio_out");
    gin[0] = 32'h0000_1234;
    repeat (3) @(negedge clk);
    txn(0, 1, 0, IO_BASE + 4, 32'h0, "rd gpio_in");
    chk("gpio_in literal", dout[0], 32'h0000_1234);

    // Counter wrap
    txn(0, 0, 1, IO_BASE + 8, 32'hFFFF_FFFE, "wr cnt");
    repeat (3) @(negedge clk);
    txn(0, 1, 0, IO_BASE + 8, 32'h0, "rd cnt");
    chk("cnt wrapped", 32'(dout[0] < 32'd64), 32'd1);

    // Zero wait states: boundaries and back-to-back
    txn(1, 0, 1, 32'h1001_03FC, 32'hCAFE_F00D, "st last");
    txn(1, 1, 0, 32'h1001_03FC, 32'h0, "ld last");
    txn(1, 1, 0, 32'h1001_0400, 32'h0, "ld past end");
    txn(1, 0, 1, 32'h1001_0000, 32'h5A5A_0001, "st word0");
    @(negedge clk);
    rd[1] = 1'b1; addr[1] = RAM_BASE;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("b2b ready %0d", k), 32'(rdy[1]), 32'(k % 2));
      if (k % 2 == 1) chk($sformatf("b2b data %0d", k), dout[1], 32'h5A5A_0001);
    end
    rd[1] = 1'b0;

    // Reset in the second wait cycle drops the store
    txn(2, 0, 1, 32'h1001_0010, 32'h2222_2222, "ws3 st");
    @(negedge clk);
    wr[2] = 1'b1; addr[2] = 32'h1001_0010; wd[2] = 32'h1111_1111;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst[2] = 1'b1; wr[2] = 1'b0;
    @(negedge clk);
    rst[2] = 1'b0;
    chk("mid reset busy", 32'(busy[2]), 32'd0);
    nrdy = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rdy[2]) nrdy++;
    end
    chk("mid reset no ready", 32'(nrdy), 32'd0);
    txn(2, 1, 0, 32'h1001_0010, 32'h0, "ws3 ld after reset");
    chk("ws3 prior content", dout[2], 32'h2222_2222);

    // Randomized traffic on the one- and zero-wait-state instances
    for (int i = 0; i < 160; i++) begin
      int d;
      d   = int'($urandom_range(0, 1));
      cls = int'($urandom_range(0, 9));
      case (cls)
        0, 1, 2, 3: a = RAM_BASE + 4 * $urandom_range(0, 15);
        4:          a = RAM_BASE + 4 * (DEPTH - 1);
        5:          a = IO_BASE;
        6:          a = IO_BASE + 4;
        7:          a = IO_BASE + 8;
        8:          a = RAM_BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
        default:    a = RAM_BASE + 4 * DEPTH + 4 * $urandom_range(0, 3);
      endcase
      v  = $urandom;
      op = int'($urandom_range(0, 9));
      if (op < 5)      txn(d, 1, 0, a, v, $sformatf("rnd%0d rd", i));
      else if (op < 9) txn(d, 0, 1, a, v, $sformatf("rnd%0d wr", i));
      else             txn(d, 1, 1, a, v, $sformatf("rnd%0d rdwr", i));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
